simon_key_sched: RTL and testbench



---
 rtl/simon_key_sched.sv | 100 ++++++++++
 tb/tb_simon_key_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_sched.sv
// simon_key_sched: round-key generator for Simon 64/128.
// Holds a 4-word key shift register and expands k(i+4) on each accepted
// valid/ready handshake. It drives the external z-sequence generator
// (zg_start / zg_compute) and consumes its z bit.
// Optional feature macro: SIMON_KS_REWIND_EN adds a `rewind` input and a
// shadow copy of the last loaded key, so the schedule can restart without
// presenting the key again.
module simon_key_sched #(
    parameter int N = 32,
    parameter int M = 4,
    parameter int T = 44
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*M-1:0] key_in,
    input  logic           key_load,
`ifdef SIMON_KS_REWIND_EN
    input  logic           rewind,
`endif
    input  logic           rk_ready,
    output logic           rk_valid,
    output logic [N-1:0]   rk,
    output logic [5:0]     rk_idx,
    output logic           busy,
    output logic           done,
    output logic           zg_start,
    output logic           zg_compute,
    input  logic           zg_z
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [M-1:0][N-1:0] kreg;      // kreg[0] is the current round key
    logic [5:0]          idx;
    logic                fire;
    logic                load_go;
    logic [M-1:0][N-1:0] load_key;
    logic [N-1:0]        tmp0;
    logic [N-1:0]        tmp;
    logic [N-1:0]        knew;

`ifdef SIMON_KS_REWIND_EN
    logic [M-1:0][N-1:0] shadow;
    logic                rewind_go;

    // Remember the most recently loaded master key for later rewinds
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shadow <= '0;
        else if (key_load)
            shadow <= key_in;
    end

    // A fresh key_load takes priority; rewind is meaningless before any load
    assign rewind_go = rewind & ~key_load & (state != IDLE);
    assign load_go   = key_load | rewind_go;
    assign load_key  = key_load ? key_in : shadow;
`else
    assign load_go   = key_load;
    assign load_key  = key_in;
`endif

    assign rk_valid   = (state == RUN);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign rk         = kreg[0];
    assign rk_idx     = idx;
    assign fire       = rk_valid & rk_ready;

    // The z generator restarts with every (re)load and advances on every
    // accepted key, including the final four whose expansion is discarded.
    assign zg_start   = load_go;
    assign zg_compute = fire & ~load_go;

    // Key expansion: tmp = ROR3(k[i+3]) ^ k[i+1]; tmp ^= ROR1(tmp);
    // new = ~k[i] ^ tmp ^ z ^ 3
    assign tmp0 = {kreg[M-1][2:0], kreg[M-1][N-1:3]} ^ kreg[1];
    assign tmp  = tmp0 ^ {tmp0[0], tmp0[N-1:1]};
    assign knew = ~kreg[0] ^ tmp ^ N'(zg_z) ^ N'(3);

    // Schedule FSM: load/restart, shift-and-expand on handshake, stop after T keys
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kreg  <= '0;
            idx   <= '0;
        end else if (load_go) begin
            state <= RUN;
            kreg  <= load_key;
            idx   <= '0;
        end else if (fire) begin
            kreg <= {knew, kreg[M-1:1]};
            idx  <= idx + 6'd1;
            if (idx == 6'(T - 1))
                state <= DONE;
        end
    end

endmodule

// File: tb/tb_simon_key_sched.sv
// Self-checking bench for simon_key_sched: a behavioural z3 generator feeds
// zg_z, and an arithmetic reference model produces k0..k43 per master key.
module tb_simon_key_sched;

    localparam int T = 44;
    localparam logic [127:0] KEY_TV = 128'h1b1a1918_13121110_0b0a0908_03020100;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         rk_ready;
    logic         rk_valid;
    logic [31:0]  rk;
    logic [5:0]   rk_idx;
    logic         busy;
    logic         done;
    logic         zg_start;
    logic         zg_compute;
    logic         zg_z;
`ifdef SIMON_KS_REWIND_EN
    logic         rewind;
`endif

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [0:61]  zseq;
    int           zptr;
    logic [31:0]  ref_k [T];
    logic [31:0]  tv [5];

    always #5 clk = ~clk;

    simon_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_load   (key_load),
`ifdef SIMON_KS_REWIND_EN
        .rewind     (rewind),
`endif
        .rk_ready   (rk_ready),
        .rk_valid   (rk_valid),
        .rk         (rk),
        .rk_idx     (rk_idx),
        .busy       (busy),
        .done       (done),
        .zg_start   (zg_start),
        .zg_compute (zg_compute),
        .zg_z       (zg_z)
    );

    // z3 sequence generator: restart on start, advance on compute
    always @(posedge clk or posedge rst) begin
        if (rst)
            zptr <= 0;
        else if (zg_start)
            zptr <= 0;
        else if (zg_compute)
            zptr <= (zptr + 1) % 62;
    end
    assign zg_z = zseq[zptr];

    function automatic logic [31:0] ror(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    task automatic build_ref(input logic [127:0] key);
        logic [31:0] t;
        logic        zb;
        for (int i = 0; i < 4; i++)
            ref_k[i] = key[32*i +: 32];
        for (int i = 4; i < T; i++) begin
            zb = zseq[i-4];
            t  = ror(ref_k[i-1], 3) ^ ref_k[i-3];
            t  = t ^ ror(t, 1);
            ref_k[i] = ~ref_k[i-4] ^ t ^ {31'd0, zb} ^ 32'd3;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},   rk_valid,   0);
        chk({tag, "_rk"},      rk,         0);
        chk({tag, "_idx"},     rk_idx,     0);
        chk({tag, "_busy"},    busy,       0);
        chk({tag, "_done"},    done,       0);
        chk({tag, "_start"},   zg_start,   0);
        chk({tag, "_compute"}, zg_compute, 0);
    endtask

    // Present a key for one edge; zg_start must be high and zg_compute low
    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        build_ref(k);
        #1;
        chk("load_start",   zg_start,   1);
        chk("load_compute", zg_compute, 0);
        step;
        key_load = 1'b0;
        #1;
    endtask

    // Walk the schedule from round 0 up to round `stop`, checking every cycle
    task automatic run_check(input bit fixed, input bit stall, input int stop);
        int acc   = 0;
        int cyc   = 0;
        int ncomp = 0;
        while (acc < stop && cyc < 3000) begin
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            chk("run_valid",   rk_valid,   1);
            chk("run_rk",      rk,         ref_k[acc]);
            chk("run_idx",     rk_idx,     acc);
            chk("run_start",   zg_start,   0);
            chk("run_compute", zg_compute, rk_ready);
            if (fixed && acc < 5)
                chk("run_tv", rk, tv[acc]);
            if (rk_ready) begin
                acc++;
                ncomp++;
            end
            step;
            cyc++;
        end
        chk("run_budget", acc, stop);
        if (stop == T) begin
            rk_ready = 1'b1;
            #1;
            chk("end_done",    done,       1);
            chk("end_valid",   rk_valid,   0);
            chk("end_busy",    busy,       0);
            chk("end_compute", zg_compute, 0);
            chk("end_ncomp",   ncomp,      T);
        end
    endtask

    initial begin
        zseq = 62'b11110000101100111001010001001000000111101001100011010111011011;
        tv[0] = 32'h03020100; tv[1] = 32'h0b0a0908; tv[2] = 32'h13121110;
        tv[3] = 32'h1b1a1918; tv[4] = 32'h70a011c3;
        rst = 1'b1; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
`ifdef SIMON_KS_REWIND_EN
        rewind = 1'b0;
`endif
        #2;
        chk_reset("reset");
        step;
        step;
        rst = 1'b0;
        step;
        chk_reset("idle");

`ifdef SIMON_KS_REWIND_EN
        // rewind before any load is ignored
        rewind = 1'b1;
        #1;
        chk("rw_idle_start", zg_start, 0);
        step;
        rewind = 1'b0;
        chk("rw_idle_valid", rk_valid, 0);
`endif

        // Known-answer run with no stalls
        rk_ready = 1'b1;
        load(KEY_TV);
        run_check(1'b1, 1'b0, T);

`ifdef SIMON_KS_REWIND_EN
        // rewind from DONE replays the same schedule
        rewind = 1'b1;
        #1;
        chk("rw_start", zg_start, 1);
        step;
        rewind = 1'b0;
        #1;
        run_check(1'b1, 1'b0, T);
`endif

        // Same key with random back-pressure: identical sequence
        load(KEY_TV);
        run_check(1'b1, 1'b1, T);

        // Random key with random back-pressure
        load({$urandom, $urandom, $urandom, $urandom});
        run_check(1'b0, 1'b1, T);

        // key_load at round 20 overrides the handshake and restarts
        load({$urandom, $urandom, $urandom, $urandom});
        run_check(1'b0, 1'b0, 20);
        rk_ready = 1'b1;
        chk("pre_reload_idx", rk_idx, 20);
        load({$urandom, $urandom, $urandom, $urandom});
        run_check(1'b0, 1'b0, T);

        // Asynchronous reset at round 10
        load({$urandom, $urandom, $urandom, $urandom});
        run_check(1'b0, 1'b0, 10);
        chk("pre_rst_idx", rk_idx, 10);
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        step;
        rst = 1'b0;
        step;
        step;
        chk_reset("post_rst");
        load({$urandom, $urandom, $urandom, $urandom});
        run_check(1'b0, 1'b1, T);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
